spi_dda_regif: RTL

- Parametrised SPI slave register interface for DDA solver cores.
- Supersedes the fixed 32-bit, mu-only, two-variable link with an addressed command protocol.
- Provides NPARAM writable parameter registers, coherent readback of NCH state channels, and an explicit DDA step strobe.
- Sits between the chip's uio SPI pins and one DDA instance.

---
 rtl/spi_dda_regif.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_dda_regif.sv
// spi_dda_regif: SPI mode-0 slave register interface for one DDA solver core.
//
// A frame starts on a cs_n falling edge. It carries an 8-bit command
// (bit7 = write, bits[6:0] = address) followed by WORD data bits, MSB first.
// Address map:
//   0 .. NPARAM-1  parameter registers (read/write)
//   0x40 + k       snapshot of state channel k, taken at the cs_n fall (read-only)
//   0x7F           control (write-only); writing data bit0 = 1 pulses step_o
// All logic runs on clk. sclk/cs_n/mosi are asynchronous and are synchronised
// here. Reset is synchronous and active-low.
//
// Optional build macro SPI_DDA_AUTOSTEP_EN: when defined, step_o also pulses
// once, one clk after every cs_n falling edge, after the snapshot is taken.
//
// Ports:
//   clk, rst_n  system clock / synchronous active-low reset
//   sclk, cs_n, mosi  asynchronous SPI inputs (mode 0)
//   miso        serial read data (0 outside a read data phase)
//   miso_oe     high while synchronised cs_n is low
//   state_i     NCH packed DDA state words, channel k at [k*WORD +: WORD]
//   param_o     NPARAM packed parameter words, same packing
//   step_o      one-clk pulse that advances the DDA by one iteration
//   wr_o        one-clk pulse on every committed parameter write
module spi_dda_regif #(
  parameter int WORD = 16,
  parameter int NCH = 2,
  parameter int NPARAM = 4,
  parameter logic [WORD-1:0] RST_VAL = WORD'(16'h3000)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  input  logic [NCH*WORD-1:0]      state_i,
  output logic [NPARAM*WORD-1:0]   param_o,
  output logic                     step_o,
  output logic                     wr_o
);

  localparam int CW = $clog2(WORD + 8);
  localparam logic [CW-1:0] LAST_CMD   = CW'(7);
  localparam logic [CW-1:0] FIRST_DATA = CW'(8);
  localparam logic [CW-1:0] LAST_DATA  = CW'(WORD + 7);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [6:0]           cmd_sr;
  logic [WORD-2:0]      data_sr;
  logic [WORD-2:0]      rd_sr;
  logic [6:0]           addr_r;
  logic                 is_wr;
  logic                 miso_q;
  logic                 step_q;
  logic                 wr_q;
  logic [WORD-1:0]      param_q [NPARAM];
  logic [NCH*WORD-1:0]  snap_q;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1;
  logic vld_p0, vld_p1, vld_p2;

  // ---- stage p0..p2: synchronisers ----
  // vld_pN marks that stage N holds a genuine pin sample rather than a reset
  // value, so a cs_n held low through reset release is not seen as a fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_p0   <= cs_n;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    mosi_p0 <= mosi;
    mosi_p1 <= mosi_p0;
  end

  // ---- edge detect on the top two flops ----
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign cs_fall   = vld_p2 & cs_p2 & ~cs_p1;
  assign cs_rise   = ~cs_p2 & cs_p1;

  logic [7:0]      cmd_byte;
  logic [WORD-1:0] wdata;
  logic            frame_end;
  logic            commit;
  logic            param_hit;
  logic            ctrl_step;

  assign cmd_byte  = {cmd_sr, mosi_p1};
  assign wdata     = {data_sr, mosi_p1};
  // A cs_n edge in the same clk as the last sclk rise wins: the frame aborts.
  assign frame_end = (state == DATA) && sclk_rise && (cnt == LAST_DATA) && !cs_rise && !cs_fall;
  assign commit    = frame_end && is_wr;
  assign param_hit = commit && ({1'b0, addr_r} < 8'(NPARAM));
  assign ctrl_step = commit && (addr_r == 7'h7F) && wdata[0];

  // Read mux; write frames and unmapped addresses read as zero.
  logic [WORD-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    if (!is_wr) begin
      for (int k = 0; k < NPARAM; k++)
        if (addr_r == 7'(k)) rd_val = param_q[k];
      for (int k = 0; k < NCH; k++)
        if (addr_r == 7'(64 + k)) rd_val = snap_q[k*WORD +: WORD];
    end
  end

  // ---- frame FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd_sr  <= '0;
      data_sr <= '0;
      rd_sr   <= '0;
      addr_r  <= '0;
      is_wr   <= 1'b0;
      miso_q  <= 1'b0;
      step_q  <= 1'b0;
      wr_q    <= 1'b0;
      snap_q  <= '0;
    end else begin
      wr_q   <= param_hit;
      step_q <= ctrl_step;
      if (cs_rise) begin
        state  <= IDLE;
        miso_q <= 1'b0;
      end else if (cs_fall) begin
        state  <= CMD;
        cnt    <= '0;
        snap_q <= state_i;
        miso_q <= 1'b0;
`ifdef SPI_DDA_AUTOSTEP_EN
        step_q <= 1'b1;
`endif
      end else begin
        case (state)
          CMD: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              cmd_sr <= cmd_byte[6:0];
              cnt    <= cnt + 1'b1;
              if (cnt == LAST_CMD) begin
                state  <= DATA;
                addr_r <= cmd_byte[6:0];
                is_wr  <= cmd_byte[7];
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              data_sr <= wdata[WORD-2:0];
              cnt     <= cnt + 1'b1;
              if (cnt == LAST_DATA) begin
                state  <= DONE;
                miso_q <= 1'b0;
              end
            end else if (sclk_fall) begin
              // First fall after the command byte loads the word; later falls shift.
              if (cnt == FIRST_DATA) begin
                rd_sr  <= rd_val[WORD-2:0];
                miso_q <= rd_val[WORD-1];
              end else begin
                rd_sr  <= {rd_sr[WORD-3:0], 1'b0};
                miso_q <= rd_sr[WORD-2];
              end
            end
          end
          default: miso_q <= 1'b0;
        endcase
      end
    end
  end

  // ---- parameter registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NPARAM; k++) param_q[k] <= RST_VAL;
    end else begin
      for (int k = 0; k < NPARAM; k++)
        if (param_hit && addr_r == 7'(k)) param_q[k] <= wdata;
    end
  end

  for (genvar k = 0; k < NPARAM; k++) begin : g_param
    assign param_o[k*WORD +: WORD] = param_q[k];
  end

  assign miso    = miso_q;
  assign miso_oe = ~cs_p2;
  assign step_o  = step_q;
  assign wr_o    = wr_q;

endmodule
